// File: rtl/arb_rr.sv
// rtl/arb_rr.sv - round-robin / fixed-priority arbiter sharing one memory port among NREQ requesters
// Owner is granted one edge after a request is seen in IDLE and released on rdy_m, request drop or timeout.
module arb_rr #(
    parameter int NREQ = 4,
    parameter int AW   = 64,
    parameter int DW   = 64,
    parameter int MODE = 0,
    parameter int TMO  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ*AW-1:0]   addr_a,
    input  logic [NREQ*DW-1:0]   dout_a,
    output logic [NREQ*DW-1:0]   din_a,
    input  logic [NREQ-1:0]      req_a,
    input  logic [NREQ-1:0]      wr_a,
    output logic [NREQ-1:0]      rdy_a,
    output logic [NREQ-1:0]      gnt_a,
    output logic [NREQ-1:0]      err_a,
    output logic [AW-1:0]        addr_m,
    output logic [DW-1:0]        dout_m,
    input  logic [DW-1:0]        din_m,
    output logic                 req_m,
    output logic                 wr_m,
    input  logic                 rdy_m,
    output logic                 busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TMO > 0) ? $clog2(TMO + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   cur, cur_nx;
    logic [IW-1:0]   last, last_nx;
    logic [IW-1:0]   pick;
    logic            found;
    logic [IW:0]     sum;
    logic [TW-1:0]   tcnt, tcnt_nx;
    logic [NREQ-1:0] gnt_nx, err_nx;

    // Owner selection: rotating search starting just after the previous owner, or lowest index
    always_comb begin
        pick  = '0;
        found = 1'b0;
        sum   = '0;
        if (MODE == 1) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req_a[i]) begin
                    pick  = IW'(i);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = 1; i <= NREQ; i++) begin
                sum = {1'b0, last} + (IW+1)'(i);
                if (sum >= (IW+1)'(NREQ)) begin
                    sum = sum - (IW+1)'(NREQ);
                end
                if (!found && req_a[sum[IW-1:0]]) begin
                    pick  = sum[IW-1:0];
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        last_nx  = last;
        tcnt_nx  = tcnt;
        gnt_nx   = gnt_a;
        err_nx   = '0;
        case (state)
            IDLE: begin
                if (|req_a) begin
                    state_nx = BUSY;
                    cur_nx   = pick;
                    gnt_nx   = NREQ'(1) << pick;
                    tcnt_nx  = '0;
                end
            end
            BUSY: begin
                // Completion beats both a dropped request and a coincident timeout
                if (rdy_m || !req_a[cur]) begin
                    state_nx = IDLE;
                    last_nx  = cur;
                    gnt_nx   = '0;
                    tcnt_nx  = '0;
                end else if (TMO > 0 && tcnt == TW'(TMO - 1)) begin
                    state_nx = IDLE;
                    last_nx  = cur;
                    gnt_nx   = '0;
                    tcnt_nx  = '0;
                    err_nx   = NREQ'(1) << cur;
                end else if (TMO > 0) begin
                    tcnt_nx = tcnt + TW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cur   <= '0;
            last  <= IW'(NREQ - 1);
            tcnt  <= '0;
            gnt_a <= '0;
            err_a <= '0;
        end else begin
            state <= state_nx;
            cur   <= cur_nx;
            last  <= last_nx;
            tcnt  <= tcnt_nx;
            gnt_a <= gnt_nx;
            err_a <= err_nx;
        end
    end

    assign busy  = (state == BUSY);
    assign din_a = {NREQ{din_m}};

    always_comb begin
        rdy_a  = '0;
        addr_m = '0;
        dout_m = '0;
        wr_m   = 1'b0;
        req_m  = 1'b0;
        if (state == BUSY) begin
            rdy_a[cur] = rdy_m;
            addr_m     = addr_a[cur*AW +: AW];
            dout_m     = dout_a[cur*DW +: DW];
            wr_m       = wr_a[cur];
            req_m      = req_a[cur];
        end
    end

endmodule

// File: tb/tb_arb_rr.sv
// tb/tb_arb_rr.sv - self-checking bench for arb_rr: round-robin instance with timeout and fixed-priority instance
module tb_arb_rr;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*AW-1:0] addr_a;
    logic [N*DW-1:0] dout_a;
    logic [N-1:0]    req_a, wr_a;
    logic [DW-1:0]   din_m;
    logic            rdy_m0, rdy_m1;

    logic [N*DW-1:0] din_a0, din_a1;
    logic [N-1:0]    rdy_a0, gnt_a0, err_a0, rdy_a1, gnt_a1, err_a1;
    logic [AW-1:0]   addr_m0, addr_m1;
    logic [DW-1:0]   dout_m0, dout_m1;
    logic            req_m0, wr_m0, busy0, req_m1, wr_m1, busy1;

    int n_pass  = 0;
    int n_total = 0;
    int last_rr;

    always #5 clk = ~clk;

    arb_rr #(.NREQ(N), .AW(AW), .DW(DW), .MODE(0), .TMO(8)) dut0 (
        .clk(clk), .reset(rst_n), .addr_a(addr_a), .dout_a(dout_a), .din_a(din_a0),
        .req_a(req_a), .wr_a(wr_a), .rdy_a(rdy_a0), .gnt_a(gnt_a0), .err_a(err_a0),
        .addr_m(addr_m0), .dout_m(dout_m0), .din_m(din_m), .req_m(req_m0), .wr_m(wr_m0),
        .rdy_m(rdy_m0), .busy(busy0)
    );

    arb_rr #(.NREQ(N), .AW(AW), .DW(DW), .MODE(1), .TMO(0)) dut1 (
        .clk(clk), .reset(rst_n), .addr_a(addr_a), .dout_a(dout_a), .din_a(din_a1),
        .req_a(req_a), .wr_a(wr_a), .rdy_a(rdy_a1), .gnt_a(gnt_a1), .err_a(err_a1),
        .addr_m(addr_m1), .dout_m(dout_m1), .din_m(din_m), .req_m(req_m1), .wr_m(wr_m1),
        .rdy_m(rdy_m1), .busy(busy1)
    );

    // Reference: round-robin scans the ring after the previous owner; fixed priority takes the lowest set bit
    function automatic int ref_owner(int prev, logic [N-1:0] r, int mode);
        if (mode == 1) begin
            for (int k = 0; k < N; k++) if (r[k]) return k;
        end else begin
            for (int k = 1; k <= N; k++) if (r[(prev + k) % N]) return (prev + k) % N;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req_a  = '0;
        wr_a   = '0;
        rdy_m0 = 1'b0;
        rdy_m1 = 1'b0;
        din_m  = '0;
        step();
        rst_n  = 1'b1;
        last_rr = N - 1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        rdy_m0 = 1'b1;
        req_a  = 4'b1111;
        #3;
        n_total++; if (gnt_a0 !== 4'b0000) $display("FAIL reset_gnt got %b want 0000", gnt_a0); else n_pass++;
        n_total++; if (busy0 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy0); else n_pass++;
        n_total++; if (err_a0 !== 4'b0000) $display("FAIL reset_err got %b want 0000", err_a0); else n_pass++;
        n_total++; if (rdy_a0 !== 4'b0000) $display("FAIL reset_rdy got %b want 0000", rdy_a0); else n_pass++;
        n_total++; if ({req_m0, wr_m0, addr_m0, dout_m0} !== '0)
            $display("FAIL reset_mem got %b %b %h %h want zeros", req_m0, wr_m0, addr_m0, dout_m0); else n_pass++;
        do_reset();
        rdy_m0 = 1'b1;
        step();
        n_total++; if ({busy0, rdy_a0} !== 5'b0) $display("FAIL idle_rdy_ignored got busy=%b rdy=%b", busy0, rdy_a0); else n_pass++;
        rdy_m0 = 1'b0;
    endtask

    task automatic test_rr_sequence();
        int exp;
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        req_a = 4'b1111;
        #1;
        n_total++; if (gnt_a0 !== 4'b0000) $display("FAIL rr_no_early_gnt got %b want 0000", gnt_a0); else n_pass++;
        for (int t = 0; t < 5; t++) begin
            exp = ref_owner(last_rr, req_a, 0);
            step();
            n_total++; if (exp !== order[t] || gnt_a0 !== 4'(1 << exp))
                $display("FAIL rr_gnt[%0d] got %b want owner %0d", t, gnt_a0, order[t]); else n_pass++;
            step();
            n_total++; if (gnt_a0 !== 4'(1 << exp)) $display("FAIL rr_gnt_hold[%0d] got %b", t, gnt_a0); else n_pass++;
            rdy_m0 = 1'b1;
            #1;
            n_total++; if (rdy_a0 !== 4'(1 << exp)) $display("FAIL rr_rdy[%0d] got %b want %b", t, rdy_a0, 4'(1 << exp)); else n_pass++;
            step();
            rdy_m0 = 1'b0;
            n_total++; if ({busy0, gnt_a0} !== 5'b0) $display("FAIL rr_idle[%0d] got busy=%b gnt=%b", t, busy0, gnt_a0); else n_pass++;
            last_rr = exp;
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        req_a = 4'b1010;
        for (int t = 0; t < 4; t++) begin
            step();
            n_total++; if (gnt_a1 !== 4'b0010) $display("FAIL fp_gnt[%0d] got %b want 0010", t, gnt_a1); else n_pass++;
            repeat ($urandom_range(0, 2)) step();
            rdy_m1 = 1'b1;
            #1;
            n_total++; if (rdy_a1 !== 4'b0010) $display("FAIL fp_rdy[%0d] got %b want 0010", t, rdy_a1); else n_pass++;
            step();
            rdy_m1 = 1'b0;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req_a = 4'b0100;
        step();
        n_total++; if (gnt_a0 !== 4'b0100) $display("FAIL tmo_gnt got %b want 0100", gnt_a0); else n_pass++;
        for (int k = 1; k < 8; k++) begin
            step();
            n_total++; if ({busy0, err_a0} !== 5'b10000) $display("FAIL tmo_wait[%0d] got busy=%b err=%b", k, busy0, err_a0); else n_pass++;
        end
        step();
        n_total++; if ({busy0, err_a0, gnt_a0} !== 9'b0_0100_0000)
            $display("FAIL tmo_err got busy=%b err=%b gnt=%b want 0 0100 0000", busy0, err_a0, gnt_a0); else n_pass++;
        step();
        n_total++; if ({err_a0, gnt_a0} !== 8'b0000_0100) $display("FAIL tmo_regrant got err=%b gnt=%b want 0000 0100", err_a0, gnt_a0); else n_pass++;
        // Same owner, completion lands on the expiry cycle
        do_reset();
        req_a = 4'b0100;
        step();
        repeat (7) step();
        rdy_m0 = 1'b1;
        #1;
        n_total++; if (rdy_a0 !== 4'b0100) $display("FAIL tmo_rdy_win got %b want 0100", rdy_a0); else n_pass++;
        step();
        rdy_m0 = 1'b0;
        n_total++; if ({busy0, err_a0} !== 5'b0) $display("FAIL tmo_rdy_no_err got busy=%b err=%b", busy0, err_a0); else n_pass++;
    endtask

    task automatic test_req_drop();
        do_reset();
        req_a = 4'b0110;
        step();
        n_total++; if (gnt_a0 !== 4'b0010) $display("FAIL drop_gnt got %b want 0010", gnt_a0); else n_pass++;
        req_a = 4'b0100;
        #1;
        n_total++; if (req_m0 !== 1'b0) $display("FAIL drop_req_m got %b want 0", req_m0); else n_pass++;
        step();
        n_total++; if ({busy0, gnt_a0, err_a0, rdy_a0} !== 13'b0)
            $display("FAIL drop_idle got busy=%b gnt=%b err=%b rdy=%b", busy0, gnt_a0, err_a0, rdy_a0); else n_pass++;
        step();
        n_total++; if (gnt_a0 !== 4'b0100) $display("FAIL drop_next got %b want 0100", gnt_a0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_a = 4'b1000;
        step();
        n_total++; if (gnt_a0 !== 4'b1000) $display("FAIL rmid_gnt got %b want 1000", gnt_a0); else n_pass++;
        #2;
        rst_n  = 1'b0;
        rdy_m0 = 1'b1;
        #1;
        n_total++; if ({gnt_a0, busy0, req_m0, rdy_a0, err_a0} !== 14'b0)
            $display("FAIL rmid_abort got gnt=%b busy=%b req_m=%b rdy=%b err=%b", gnt_a0, busy0, req_m0, rdy_a0, err_a0); else n_pass++;
        rst_n  = 1'b1;
        rdy_m0 = 1'b0;
        req_a  = 4'b1001;
        step();
        n_total++; if (gnt_a0 !== 4'b0001) $display("FAIL rmid_after got %b want 0001", gnt_a0); else n_pass++;
    endtask

    task automatic test_random();
        int exp;
        do_reset();
        for (int t = 0; t < 40; t++) begin
            req_a  = 4'($urandom_range(1, 15));
            wr_a   = 4'($urandom);
            addr_a = {$urandom, $urandom};
            dout_a = {$urandom, $urandom};
            exp    = ref_owner(last_rr, req_a, 0);
            step();
            n_total++; if (gnt_a0 !== 4'(1 << exp)) $display("FAIL rand_gnt[%0d] got %b want owner %0d", t, gnt_a0, exp); else n_pass++;
            n_total++; if ({addr_m0, dout_m0, wr_m0, req_m0} !== {addr_a[exp*AW +: AW], dout_a[exp*DW +: DW], wr_a[exp], 1'b1})
                $display("FAIL rand_mux[%0d] got %h %h %b %b want owner %0d", t, addr_m0, dout_m0, wr_m0, req_m0, exp); else n_pass++;
            repeat ($urandom_range(0, 3)) step();
            din_m  = 16'($urandom);
            rdy_m0 = 1'b1;
            #1;
            n_total++; if (rdy_a0 !== 4'(1 << exp) || din_a0 !== {N{din_m}})
                $display("FAIL rand_rdy[%0d] got rdy=%b din=%h want owner %0d din %h", t, rdy_a0, din_a0, exp, din_m); else n_pass++;
            step();
            rdy_m0 = 1'b0;
            req_a  = '0;
            #1;
            n_total++; if ({busy0, req_m0, addr_m0} !== 18'b0) $display("FAIL rand_idle[%0d] got busy=%b req_m=%b addr=%h", t, busy0, req_m0, addr_m0); else n_pass++;
            last_rr = exp;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        addr_a = '0;
        dout_a = '0;
        req_a  = '0;
        wr_a   = '0;
        din_m  = '0;
        rdy_m0 = 1'b0;
        rdy_m1 = 1'b0;
        last_rr = N - 1;
        test_reset();
        test_rr_sequence();
        test_fixed_priority();
        test_timeout();
        test_req_drop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/arb_rr.md
ARB_RR -- requirements
Module: arb_rr

Interface
REQ-001 Parameters SHALL be:
- NREQ, default 4: number of requesters, 2..16.
- AW, default 64: address width.
- DW, default 64: data width.
- MODE, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- TMO, default 0: timeout in cycles; 0 disables the timeout.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: the single clock.
- reset, in, 1: asynchronous, active-low reset.
- addr_a, in, NREQ*AW: requester addresses; slice i is [i*AW +: AW].
- dout_a, in, NREQ*DW: requester write data.
- din_a, out, NREQ*DW: read data to requesters.
- req_a, in, NREQ: request per requester.
- wr_a, in, NREQ: write (1) / read (0) per requester.
- rdy_a, out, NREQ: completion strobe per requester.
- gnt_a, out, NREQ: one-hot current owner.
- err_a, out, NREQ: timeout abort strobe per requester.
- addr_m, out, AW: memory-side address.
- dout_m, out, DW: memory-side write data.
- din_m, in, DW: memory-side read data.
- req_m, out, 1: memory-side request.
- wr_m, out, 1: memory-side write flag.
- rdy_m, in, 1: memory-side completion.
- busy, out, 1: a transaction is in progress.

Function
REQ-003 The block SHALL implement a two-state FSM, IDLE and BUSY, with registered state cur (owner index, clog2(NREQ) bits), last (previous owner index) and tcnt (timeout counter).
REQ-004 IDLE with req_a nonzero SHALL select an owner and move to BUSY on the next edge, setting cur, gnt_a = 1<<cur and busy = 1.
- Arbitration latency is one cycle from req to gnt_a.
REQ-005 Owner selection in MODE 0 SHALL be the first asserted req_a index searched from (last+1) mod NREQ upward, wrapping.
REQ-006 Owner selection in MODE 1 SHALL be the lowest asserted req_a index; last is ignored.
REQ-007 In BUSY, the memory-side outputs SHALL be driven combinationally from the owner's signals:
- addr_m = addr_a slice cur.
- dout_m = dout_a slice cur.
- wr_m = wr_a[cur].
- req_m = req_a[cur].
REQ-008 In IDLE, the memory-side outputs SHALL be req_m = 0, wr_m = 0, addr_m = 0 and dout_m = 0.
REQ-009 rdy_a SHALL equal rdy_m & busy, routed to bit cur only; all other bits are 0.
REQ-010 rdy_m in BUSY SHALL move the FSM to IDLE on the next edge with last <= cur, gnt_a <= 0 and tcnt <= 0.
- A new grant requires at least one IDLE cycle, so there are no back-to-back grants.
REQ-011 rdy_m in IDLE SHALL be ignored: no state change and rdy_a = 0.
REQ-012 If the owner deasserts req_a[cur] in BUSY without rdy_m, the FSM SHALL return to IDLE next edge with last <= cur and no rdy_a or err_a.
REQ-013 With TMO > 0, tcnt SHALL increment each BUSY cycle without rdy_m.
- When tcnt reaches TMO-1 without rdy_m, err_a[cur] pulses for one cycle on that edge.
- On the same edge the FSM goes to IDLE with last <= cur.
REQ-014 If rdy_m and timeout expiry coincide, rdy_m SHALL win: rdy_a strobes and err_a stays 0.
REQ-015 din_a SHALL broadcast din_m to every slice, combinationally.
REQ-016 gnt_a and err_a SHALL be registered; rdy_a, req_m and the memory-side mux outputs are combinational.
REQ-017 tcnt width SHALL be clog2(TMO+1) bits with no wrap beyond TMO.

Reset
REQ-018 On reset low, asynchronously, the block SHALL force:
- state = IDLE, cur = 0, last = NREQ-1, tcnt = 0.
- gnt_a = 0, err_a = 0, busy = 0.
- Consequently the first round-robin grant favours requester 0.
REQ-019 Reset asserted mid-transaction SHALL abort it silently: no rdy_a, no err_a, and outputs at their REQ-008 values.
REQ-020 After reset deasserts, the first grant SHALL occur no earlier than one edge after a req is sampled.

Verification
REQ-021 NREQ=4, MODE 0, req_a=4'b1111 held, rdy_m pulsed one cycle after each grant -> grant order 0,1,2,3,0; each gnt_a lasts 2 cycles, then 1 IDLE cycle.
REQ-022 MODE 1, req_a=4'b1010 held, rdy_m each transaction -> owner always 1; requester 3 is never granted.
REQ-023 TMO=8, req_a=4'b0100, rdy_m held 0 -> err_a=4'b0100 for one cycle 8 cycles after grant, then IDLE; a subsequent round-robin grant goes to requester 2 again (only requester).
REQ-024 TMO=8, rdy_m=1 on the exact expiry cycle -> rdy_a=4'b0100, err_a=0.
REQ-025 Owner 1 drops req mid-transaction -> IDLE next edge, no strobes; the pending req 2 is granted one cycle later.
REQ-026 reset pulsed low while BUSY with owner 3 -> gnt_a=0, busy=0 immediately, req_m=0; after release, req_a=4'b1001 -> owner 0.
